// File: rtl/ex_rs_pkg.sv
// ex_rs_pkg: shared types and helpers for the ex_reserv_station slice.
// - Field widths of a station entry (tag, operand, op, payload).
// - TAG_INVALID: tag value meaning "operand value already present".
// - rs_entry_t: one reservation-station slot.
// - tag_match: broadcast-vs-operand tag compare used by the wakeup logic.
// Entry field widths live here so the entry record can be a single packed
// type; change them here to retarget the station.
package ex_rs_pkg;

  localparam int RS_NUM_SRC = 2;
  localparam int RS_TAG_W   = 4;
  localparam int RS_DATA_W  = 32;
  localparam int RS_OP_W    = 5;
  localparam int RS_EXTRA_W = 35;

  localparam logic [RS_TAG_W-1:0] TAG_INVALID = '0;

  typedef struct packed {
    logic                                  valid;
    logic [RS_TAG_W-1:0]                   target;
    logic [RS_OP_W-1:0]                    op;
    logic [RS_NUM_SRC-1:0][RS_DATA_W-1:0]  val;
    logic [RS_NUM_SRC-1:0][RS_TAG_W-1:0]   tag;
    logic [RS_EXTRA_W-1:0]                 extra;
  } rs_entry_t;

  // A pending operand (tag != TAG_INVALID) is satisfied by a broadcast of
  // the same tag. A present operand never matches, even a tag-0 broadcast.
  function automatic logic tag_match(input logic [RS_TAG_W-1:0] op_tag,
                                     input logic [RS_TAG_W-1:0] bc_tag);
    return (op_tag != TAG_INVALID) && (op_tag == bc_tag);
  endfunction

endpackage

// File: rtl/ex_reserv_station_if.sv
// ex_reserv_station_if: dispatch, broadcast, issue and status bundle of the
// reservation station.
// - slave  : the station side (consumes dispatch/broadcast/iss_ready/flush).
// - master : the idex/execution-unit side driving the station.
// Signals: flush; disp_valid/ready/target/op/val/tag/extra; bc_valid/tag/val;
//          iss_valid/ready/target/op/val/extra; count; full.
interface ex_reserv_station_if
  import ex_rs_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_BCAST = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                                  flush;

  logic                                  disp_valid;
  logic                                  disp_ready;
  logic [RS_TAG_W-1:0]                   disp_target;
  logic [RS_OP_W-1:0]                    disp_op;
  logic [RS_NUM_SRC-1:0][RS_DATA_W-1:0]  disp_val;
  logic [RS_NUM_SRC-1:0][RS_TAG_W-1:0]   disp_tag;
  logic [RS_EXTRA_W-1:0]                 disp_extra;

  logic [NUM_BCAST-1:0]                  bc_valid;
  logic [NUM_BCAST-1:0][RS_TAG_W-1:0]    bc_tag;
  logic [NUM_BCAST-1:0][RS_DATA_W-1:0]   bc_val;

  logic                                  iss_valid;
  logic                                  iss_ready;
  logic [RS_TAG_W-1:0]                   iss_target;
  logic [RS_OP_W-1:0]                    iss_op;
  logic [RS_NUM_SRC-1:0][RS_DATA_W-1:0]  iss_val;
  logic [RS_EXTRA_W-1:0]                 iss_extra;

  logic [CNT_W-1:0]                      count;
  logic                                  full;

  modport slave (
    input  flush,
    input  disp_valid, disp_target, disp_op, disp_val, disp_tag, disp_extra,
    output disp_ready,
    input  bc_valid, bc_tag, bc_val,
    output iss_valid, iss_target, iss_op, iss_val, iss_extra,
    input  iss_ready,
    output count, full
  );

  modport master (
    output flush,
    output disp_valid, disp_target, disp_op, disp_val, disp_tag, disp_extra,
    input  disp_ready,
    output bc_valid, bc_tag, bc_val,
    input  iss_valid, iss_target, iss_op, iss_val, iss_extra,
    output iss_ready,
    input  count, full
  );

endinterface

// File: rtl/ex_rs_wakeup.sv
// ex_rs_wakeup: broadcast snoop for a single operand.
// - tag_in/val_in     : current operand tag and value.
// - bc_valid/tag/val  : all broadcast channels of this cycle.
// - tag_out/val_out   : operand after wakeup (TAG_INVALID + broadcast value
//                       on a hit, unchanged otherwise).
// When several channels carry the same tag, the lowest channel index wins.
module ex_rs_wakeup
  import ex_rs_pkg::*;
#(
  parameter int NUM_BCAST = 2
) (
  input  logic [RS_TAG_W-1:0]                  tag_in,
  input  logic [RS_DATA_W-1:0]                 val_in,
  input  logic [NUM_BCAST-1:0]                 bc_valid,
  input  logic [NUM_BCAST-1:0][RS_TAG_W-1:0]   bc_tag,
  input  logic [NUM_BCAST-1:0][RS_DATA_W-1:0]  bc_val,
  output logic [RS_TAG_W-1:0]                  tag_out,
  output logic [RS_DATA_W-1:0]                 val_out
);

  logic hit;

  always_comb begin
    hit     = 1'b0;
    tag_out = tag_in;
    val_out = val_in;
    for (int k = 0; k < NUM_BCAST; k++) begin
      if (!hit && bc_valid[k] && tag_match(tag_in, bc_tag[k])) begin
        hit     = 1'b1;
        tag_out = TAG_INVALID;
        val_out = bc_val[k];
      end
    end
  end

endmodule

// File: rtl/ex_reserv_station.sv
// ex_reserv_station: reservation station in front of one execution unit.
// - clk : rising-edge clock.
// - rst : asynchronous, active-low reset.
// - bus : ex_reserv_station_if.slave (dispatch in, broadcast snoop, issue
//         out, flush, count/full status).
// Entries form a collapsing queue with index 0 the oldest. Every cycle each
// stored operand snoops the broadcasts; the oldest entry whose operands were
// all present in registered state is offered for issue. On an issue the
// younger entries slide down one slot, then a dispatched op is appended at
// the first free slot, so dispatch+issue in one cycle leaves count unchanged.
module ex_reserv_station
  import ex_rs_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_BCAST = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ex_reserv_station_if.slave    bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SEL_W = $clog2(DEPTH);

  rs_entry_t entry_q [DEPTH];
  rs_entry_t entry_d [DEPTH];
  rs_entry_t woke    [DEPTH];
  rs_entry_t shifted [DEPTH];
  rs_entry_t disp_entry;

  logic [CNT_W-1:0] count_q, count_d, count_after;

  logic [RS_NUM_SRC-1:0][RS_TAG_W-1:0]  woke_tag [DEPTH];
  logic [RS_NUM_SRC-1:0][RS_DATA_W-1:0] woke_val [DEPTH];
  logic [RS_NUM_SRC-1:0][RS_TAG_W-1:0]  disp_tag_w;
  logic [RS_NUM_SRC-1:0][RS_DATA_W-1:0] disp_val_w;

  logic [DEPTH-1:0] ready;
  logic [SEL_W-1:0] sel_idx;
  logic             any_ready;
  logic             full_w;
  logic             disp_fire;
  logic             iss_fire;

  // Per-entry, per-operand wakeup, plus the ready flag of each entry built
  // from registered tags only (a broadcast never enables same-cycle issue).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    for (genvar gs = 0; gs < RS_NUM_SRC; gs++) begin : g_src
      ex_rs_wakeup #(.NUM_BCAST(NUM_BCAST)) u_wakeup (
        .tag_in   (entry_q[gi].tag[gs]),
        .val_in   (entry_q[gi].val[gs]),
        .bc_valid (bus.bc_valid),
        .bc_tag   (bus.bc_tag),
        .bc_val   (bus.bc_val),
        .tag_out  (woke_tag[gi][gs]),
        .val_out  (woke_val[gi][gs])
      );
    end

    always_comb begin
      woke[gi]     = entry_q[gi];
      woke[gi].tag = woke_tag[gi];
      woke[gi].val = woke_val[gi];
    end

    always_comb begin
      ready[gi] = entry_q[gi].valid;
      for (int s = 0; s < RS_NUM_SRC; s++) begin
        if (entry_q[gi].tag[s] != TAG_INVALID) ready[gi] = 1'b0;
      end
    end

    // Slots at or above the issued one take their younger neighbour; the
    // top slot empties.
    if (gi == DEPTH - 1) begin : g_top
      always_comb begin
        shifted[gi] = (iss_fire && (SEL_W'(gi) >= sel_idx)) ? '0 : woke[gi];
      end
    end else begin : g_mid
      always_comb begin
        shifted[gi] = (iss_fire && (SEL_W'(gi) >= sel_idx)) ? woke[gi+1] : woke[gi];
      end
    end
  end

  // Dispatched operands snoop the same-cycle broadcasts so no wakeup is lost.
  for (genvar gs = 0; gs < RS_NUM_SRC; gs++) begin : g_disp_src
    ex_rs_wakeup #(.NUM_BCAST(NUM_BCAST)) u_disp_wakeup (
      .tag_in   (bus.disp_tag[gs]),
      .val_in   (bus.disp_val[gs]),
      .bc_valid (bus.bc_valid),
      .bc_tag   (bus.bc_tag),
      .bc_val   (bus.bc_val),
      .tag_out  (disp_tag_w[gs]),
      .val_out  (disp_val_w[gs])
    );
  end

  always_comb begin
    disp_entry        = '0;
    disp_entry.valid  = 1'b1;
    disp_entry.target = bus.disp_target;
    disp_entry.op     = bus.disp_op;
    disp_entry.val    = disp_val_w;
    disp_entry.tag    = disp_tag_w;
    disp_entry.extra  = bus.disp_extra;
  end

  // Oldest ready entry: scan downwards so the lowest index is the last hit.
  always_comb begin
    sel_idx   = '0;
    any_ready = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        any_ready = 1'b1;
        sel_idx   = SEL_W'(i);
      end
    end
  end

  assign full_w         = (count_q == CNT_W'(DEPTH));
  assign bus.full       = full_w;
  assign bus.count      = count_q;
  assign bus.disp_ready = !full_w && !bus.flush;
  assign bus.iss_valid  = any_ready && !bus.flush;

  assign disp_fire = bus.disp_valid && bus.disp_ready;
  assign iss_fire  = bus.iss_valid && bus.iss_ready;

  always_comb begin
    bus.iss_target = '0;
    bus.iss_op     = '0;
    bus.iss_val    = '0;
    bus.iss_extra  = '0;
    if (any_ready) begin
      bus.iss_target = entry_q[sel_idx].target;
      bus.iss_op     = entry_q[sel_idx].op;
      bus.iss_val    = entry_q[sel_idx].val;
      bus.iss_extra  = entry_q[sel_idx].extra;
    end
  end

  // Remove/shift first, then append at the post-shift occupancy.
  always_comb begin
    count_after = count_q - CNT_W'(iss_fire);
    count_d     = count_after + CNT_W'(disp_fire);
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = shifted[i];
      if (disp_fire && (CNT_W'(i) == count_after)) entry_d[i] = disp_entry;
    end
    if (bus.flush) begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) entry_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

  // Dispatching into a full station is an upstream protocol error.
  a_no_disp_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(bus.disp_valid && full_w && !bus.flush))
    else $error("ex_reserv_station: dispatch while full");

endmodule

// File: tb/tb_ex_reserv_station.sv
module tb_ex_reserv_station;
  import ex_rs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_reserv_station_if #(.DEPTH(4), .NUM_BCAST(2)) bus ();

  ex_reserv_station #(.DEPTH(4), .NUM_BCAST(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        dv;
    logic [3:0]  dtgt;
    logic [3:0]  dt0, dt1;
    logic [31:0] dv0, dv1;
    logic [1:0]  bcv;
    logic [3:0]  bt0, bt1;
    logic [31:0] bv0, bv1;
    logic        ir, fl;
    logic        eiv;
    logic [3:0]  etgt;
    logic [31:0] ev0, ev1;
    logic [2:0]  ecnt;
    logic        efull, erdy;
  } vec_t;

  vec_t tbl [16];
  vec_t exp_q [$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  function automatic logic [34:0] extra_of(input logic [3:0] t);
    return {t, 27'h5A5A5A5, t};
  endfunction

  function automatic logic [4:0] op_of(input logic [3:0] t);
    return {1'b1, t};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.flush       = v.fl;
    bus.disp_valid  = v.dv;
    bus.disp_target = v.dtgt;
    bus.disp_op     = op_of(v.dtgt);
    bus.disp_tag[0] = v.dt0;
    bus.disp_tag[1] = v.dt1;
    bus.disp_val[0] = v.dv0;
    bus.disp_val[1] = v.dv1;
    bus.disp_extra  = extra_of(v.dtgt);
    bus.bc_valid    = v.bcv;
    bus.bc_tag[0]   = v.bt0;
    bus.bc_tag[1]   = v.bt1;
    bus.bc_val[0]   = v.bv0;
    bus.bc_val[1]   = v.bv1;
    bus.iss_ready   = v.ir;
  endtask

  task automatic check_out();
    vec_t e;
    e = exp_q.pop_front();
    $display("[TB] cyc %0d disp=%0b tgt=%0d iss_v=%0b iss_tgt=%0d val={%0h,%0h} cnt=%0d full=%0b drdy=%0b",
             cyc, e.dv, e.dtgt, bus.iss_valid, bus.iss_target, bus.iss_val[0], bus.iss_val[1],
             bus.count, bus.full, bus.disp_ready);
    chk("iss_valid", 64'(bus.iss_valid), 64'(e.eiv));
    chk("count", 64'(bus.count), 64'(e.ecnt));
    chk("full", 64'(bus.full), 64'(e.efull));
    chk("disp_ready", 64'(bus.disp_ready), 64'(e.erdy));
    if (e.eiv) begin
      chk("iss_target", 64'(bus.iss_target), 64'(e.etgt));
      chk("iss_val0", 64'(bus.iss_val[0]), 64'(e.ev0));
      chk("iss_val1", 64'(bus.iss_val[1]), 64'(e.ev1));
      chk("iss_op", 64'(bus.iss_op), 64'(op_of(e.etgt)));
      chk("iss_extra", 64'(bus.iss_extra), 64'(extra_of(e.etgt)));
    end
  endtask

  // One cycle: drive at negedge, queue the expectation, sample 1ns later.
  task automatic step(input vec_t v);
    @(negedge clk);
    cyc++;
    drive(v);
    exp_q.push_back(v);
    #1;
    check_out();
  endtask

  task automatic idle_inputs();
    bus.flush = 0; bus.disp_valid = 0; bus.disp_target = 0; bus.disp_op = 0;
    bus.disp_tag = '0; bus.disp_val = '0; bus.disp_extra = '0;
    bus.bc_valid = 0; bus.bc_tag = '0; bus.bc_val = '0; bus.iss_ready = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_iss_valid"}, 64'(bus.iss_valid), 64'd0);
    chk({tag, "_count"}, 64'(bus.count), 64'd0);
    chk({tag, "_full"}, 64'(bus.full), 64'd0);
    chk({tag, "_disp_ready"}, 64'(bus.disp_ready), 64'd1);
    chk({tag, "_iss_target"}, 64'(bus.iss_target), 64'd0);
    chk({tag, "_iss_val0"}, 64'(bus.iss_val[0]), 64'd0);
    chk({tag, "_iss_val1"}, 64'(bus.iss_val[1]), 64'd0);
    chk({tag, "_iss_extra"}, 64'(bus.iss_extra), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    //        dv tgt t0 t1 v0     v1     bcv    bt0 bt1 bv0    bv1    ir fl | eiv tgt ev0    ev1    cnt full rdy
    tbl[0]  = '{1, 3, 0, 0, 'h5,   'h7,   2'b00, 0, 0, 0,     0,     0, 0,   0, 0, 0,     0,     0, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 0,     0,     2'b00, 0, 0, 0,     0,     1, 0,   1, 3, 'h5,   'h7,   1, 0, 1};
    tbl[2]  = '{1, 4, 9, 0, 0,     'h22,  2'b00, 0, 0, 0,     0,     1, 0,   0, 0, 0,     0,     0, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 0,     0,     2'b00, 0, 0, 0,     0,     1, 0,   0, 0, 0,     0,     1, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 0,     0,     2'b10, 0, 9, 0,     'hAB,  0, 0,   0, 0, 0,     0,     1, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0,     0,     2'b00, 0, 0, 0,     0,     1, 0,   1, 4, 'hAB,  'h22,  1, 0, 1};
    tbl[6]  = '{1, 5, 6, 0, 0,     'h33,  2'b01, 6, 0, 'h11,  0,     0, 0,   0, 0, 0,     0,     0, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 0,     0,     2'b00, 0, 0, 0,     0,     1, 0,   1, 5, 'h11,  'h33,  1, 0, 1};
    tbl[8]  = '{1, 6, 7, 8, 0,     0,     2'b00, 0, 0, 0,     0,     0, 0,   0, 0, 0,     0,     0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0,     0,     2'b11, 7, 7, 'h70,  'h71,  0, 0,   0, 0, 0,     0,     1, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0,     0,     2'b01, 8, 0, 'h88,  0,     0, 0,   0, 0, 0,     0,     1, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0,     0,     2'b00, 0, 0, 0,     0,     1, 0,   1, 6, 'h70,  'h88,  1, 0, 1};
    tbl[12] = '{1, 7, 0, 0, 'h1,   'h2,   2'b00, 0, 0, 0,     0,     0, 0,   0, 0, 0,     0,     0, 0, 1};
    tbl[13] = '{1, 8, 0, 0, 'h3,   'h4,   2'b00, 0, 0, 0,     0,     1, 0,   1, 7, 'h1,   'h2,   1, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 0,     0,     2'b00, 0, 0, 0,     0,     1, 0,   1, 8, 'h3,   'h4,   1, 0, 1};
    tbl[15] = '{0, 0, 0, 0, 0,     0,     2'b00, 0, 0, 0,     0,     0, 0,   0, 0, 0,     0,     0, 0, 1};

    idle_inputs();
    #2 rst = 1'b0;
    #1 check_reset_state("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) step(tbl[i]);

    // Fill four pending entries, wake slot 2 only, then out-of-order wakeups
    // that force the selector back onto older entries while stalled.
    step('{1, 1, 1, 0, 0, 'h10, 2'b00, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1});
    step('{1, 2, 2, 0, 0, 'h20, 2'b00, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1});
    step('{1, 3, 3, 0, 0, 'h30, 2'b00, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2, 0, 1});
    step('{1, 4, 4, 0, 0, 'h40, 2'b00, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0, 1});
    step('{0, 0, 0, 0, 0, 0, 2'b01, 3, 0, 'h3A, 0, 0, 0,   0, 0, 0, 0, 4, 1, 0});
    step('{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0,      1, 3, 'h3A, 'h30, 4, 1, 0});
    step('{0, 0, 0, 0, 0, 0, 2'b10, 0, 4, 0, 'h4A, 0, 0,   0, 0, 0, 0, 3, 0, 1});
    step('{0, 0, 0, 0, 0, 0, 2'b01, 2, 0, 'h2A, 0, 0, 0,   1, 4, 'h4A, 'h40, 3, 0, 1});
    step('{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,      1, 2, 'h2A, 'h20, 3, 0, 1});
    step('{0, 0, 0, 0, 0, 0, 2'b10, 0, 1, 0, 'h1A, 0, 0,   1, 2, 'h2A, 'h20, 3, 0, 1});
    step('{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,      1, 1, 'h1A, 'h10, 3, 0, 1});
    step('{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0,      1, 1, 'h1A, 'h10, 3, 0, 1});
    step('{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,      1, 2, 'h2A, 'h20, 2, 0, 1});
    step('{1, 9, 5, 0, 0, 'h90, 2'b00, 0, 0, 0, 0, 0, 0,   1, 2, 'h2A, 'h20, 2, 0, 1});
    step('{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,      1, 2, 'h2A, 'h20, 3, 0, 1});

    // Flush with dispatch and issue requested: both suppressed, station empties.
    step('{1, 10, 0, 0, 'h5, 'h6, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3, 0, 0});
    step('{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0,      0, 0, 0, 0, 0, 0, 1});

    // Reset asserted mid-stream clears outputs without waiting for an edge.
    step('{1, 11, 0, 0, 'hB1, 'hB2, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    step('{1, 12, 0, 0, 'hC1, 'hC2, 2'b00, 0, 0, 0, 0, 0, 0, 1, 11, 'hB1, 'hB2, 1, 0, 1});
    @(negedge clk);
    idle_inputs();
    #1 rst = 1'b0;
    #1 check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b1;
    step('{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
